alu_fpga_console: RTL and testbench

ALU_FPGA_CONSOLE -- requirements
Module: alu_fpga_console

---
 rtl/alu_fpga_console.sv | 193 +++++++++++++++++++
 tb/tb_alu_fpga_console.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_fpga_console.sv
// Front-panel console for an external ALU: debounced keys load operands and the
// opcode, start a fixed-latency execute, and select what the seven-segment bank shows.
module alu_fpga_console #(
  parameter int DATA_W     = 32,
  parameter int DIGITS     = DATA_W / 4,
  parameter int DEB_CYCLES = 250000,
  parameter int ALU_LAT    = 1,
  parameter int BLANK_LZ   = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [3:0]          KEY,
  input  logic [17:0]         SW,
  output logic [3:0]          op_o,
  output logic [DATA_W-1:0]   in1_o,
  output logic [DATA_W-1:0]   in2_o,
  input  logic [DATA_W-1:0]   result_i,
  output logic                busy_o,
  output logic [1:0]          mode_o,
  output logic [DIGITS*7-1:0] HEX
);

  localparam int unsigned NIB = DATA_W / 4;
  localparam int unsigned DCW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned LCW = $clog2(ALU_LAT + 1);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);
  localparam logic [LCW-1:0] LAT_INIT = LCW'(ALU_LAT);

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b0100111;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Digits above the top nonzero nibble go dark; digit 0 always shows.
  function automatic logic [DIGITS*7-1:0] hex_encode(input logic [DATA_W-1:0] v);
    logic [DIGITS*7-1:0] segs;
    int unsigned         msn;
    segs = '1;
    msn  = 0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (v[4*i +: 4] != 4'h0) msn = i;
    end
    for (int unsigned k = 0; k < NIB && k < DIGITS; k++) begin
      if (BLANK_LZ == 0 || k <= msn) segs[7*k +: 7] = seg7(v[4*k +: 4]);
    end
    return segs;
  endfunction

  localparam logic [DIGITS*7-1:0] HEX_RST = hex_encode({DATA_W{1'b0}});

  typedef enum logic {S_IDLE, S_EXEC} state_e;

  logic [3:0]     key_s1_q, key_s2_q, key_deb_q, press_q;
  logic [DCW-1:0] deb_cnt_q [4];
  logic [17:0]    sw_s1_q, sw_s2_q;
  logic [DATA_W-1:0] sw_val;

  state_e            state_q;
  logic [LCW-1:0]    lat_q;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] in1_q, in2_q, result_q;
  logic              busy_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] src_d;
  logic [DIGITS*7-1:0] hex_d, hex_q;

  // Press pulse is raised on the same edge the debounced level falls.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      key_s1_q  <= '1;
      key_s2_q  <= '1;
      key_deb_q <= '1;
      press_q   <= '0;
      for (int unsigned k = 0; k < 4; k++) deb_cnt_q[k] <= '0;
    end else begin
      key_s1_q <= KEY;
      key_s2_q <= key_s1_q;
      press_q  <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        if (key_s2_q[k] == key_deb_q[k]) begin
          deb_cnt_q[k] <= '0;
        end else if (deb_cnt_q[k] == DEB_LAST) begin
          deb_cnt_q[k] <= '0;
          key_deb_q[k] <= key_s2_q[k];
          press_q[k]   <= ~key_s2_q[k];
        end else begin
          deb_cnt_q[k] <= deb_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= SW;
      sw_s2_q <= sw_s1_q;
    end
  end

  generate
    if (DATA_W > 16) begin : g_sext
      assign sw_val = {{(DATA_W-16){sw_s2_q[16]}}, sw_s2_q[15:0]};
    end else if (DATA_W == 16) begin : g_full
      assign sw_val = sw_s2_q[15:0];
    end else begin : g_trunc
      assign sw_val = sw_s2_q[DATA_W-1:0];
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      lat_q    <= '0;
      op_q     <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      mode_q   <= '0;
    end else begin
      if (press_q[3]) mode_q <= mode_q + 2'd1;
      unique case (state_q)
        S_IDLE: begin
          if (press_q[0]) begin
            if (sw_s2_q[17]) in2_q <= sw_val;
            else             in1_q <= sw_val;
          end
          if (press_q[1]) op_q <= sw_s2_q[3:0];
          if (press_q[2]) begin
            state_q <= S_EXEC;
            busy_q  <= 1'b1;
            lat_q   <= LAT_INIT;
          end
        end
        S_EXEC: begin
          if (lat_q == '0) begin
            result_q <= result_i;
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    src_d = '0;
    unique case (mode_q)
      2'd0:    src_d = result_q;
      2'd1:    src_d = in1_q;
      2'd2:    src_d = in2_q;
      default: src_d = {{(DATA_W-4){1'b0}}, op_q};
    endcase
    hex_d = hex_encode(src_d);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) hex_q <= HEX_RST;
    else     hex_q <= hex_d;
  end

  assign op_o   = op_q;
  assign in1_o  = in1_q;
  assign in2_o  = in2_q;
  assign busy_o = busy_q;
  assign mode_o = mode_q;
  assign HEX    = hex_q;

endmodule

// File: tb/tb_alu_fpga_console.sv
// Self-checking bench for alu_fpga_console: directed scenarios plus a randomized
// key/switch sequence checked against a register-level model of the console.
module tb_alu_fpga_console;

  localparam int DATA_W = 32;
  localparam int DIGITS = 8;

  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [55:0] HEX_RST = {{7{7'b1111111}}, 7'b1000000};

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  KEY;
  logic [17:0] SW;
  logic [3:0]  op_o;
  logic [31:0] in1_o, in2_o, result_i;
  logic        busy_o;
  logic [1:0]  mode_o;
  logic [55:0] HEX;

  logic        fixed_en;
  logic [31:0] fixed_val;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned busy_cycles = 0;

  logic [31:0] m_in1, m_in2, m_res;
  logic [3:0]  m_op;
  logic [1:0]  m_mode;

  alu_fpga_console #(
    .DATA_W(DATA_W), .DIGITS(DIGITS), .DEB_CYCLES(4), .ALU_LAT(2), .BLANK_LZ(1)
  ) dut (
    .CLK(CLK), .RST(RST), .KEY(KEY), .SW(SW),
    .op_o(op_o), .in1_o(in1_o), .in2_o(in2_o), .result_i(result_i),
    .busy_o(busy_o), .mode_o(mode_o), .HEX(HEX)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (busy_o === 1'b1) busy_cycles++;

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] op);
    case (op)
      4'h1:    return a - b;
      4'h2:    return a & b;
      4'h3:    return a | b;
      4'h4:    return a ^ b;
      4'h5:    return ~a;
      default: return a + b;
    endcase
  endfunction

  assign result_i = fixed_en ? fixed_val : alu(in1_o, in2_o, op_o);

  // Count significant hex digits, light that many, blank the rest.
  function automatic logic [55:0] exp_hex(input logic [31:0] v);
    logic [55:0] h;
    logic [31:0] t;
    int          ndig;
    ndig = 1;
    t = v >> 4;
    while (t != 0) begin
      ndig++;
      t = t >> 4;
    end
    for (int d = 0; d < 8; d++)
      h[7*d +: 7] = (d < ndig) ? SEG[(v >> (4*d)) & 32'hF] : 7'b1111111;
    return h;
  endfunction

  function automatic logic [31:0] disp_src();
    case (m_mode)
      2'd0:    return m_res;
      2'd1:    return m_in1;
      2'd2:    return m_in2;
      default: return {28'h0, m_op};
    endcase
  endfunction

  function automatic logic [31:0] sw_ext(input logic [17:0] s);
    return {{16{s[16]}}, s[15:0]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input logic [3:0] mask, input int hold);
    @(negedge CLK);
    KEY = ~mask;
    tick(hold);
    KEY = 4'hF;
    tick(12);
  endtask

  task automatic set_mode(input logic [1:0] target);
    for (int i = 0; i < 4 && m_mode != target; i++) begin
      press(4'b1000, 6);
      m_mode = m_mode + 2'd1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; KEY = 4'hF; SW = '0; fixed_en = 1'b0; fixed_val = '0;
    m_in1 = '0; m_in2 = '0; m_res = '0; m_op = '0; m_mode = '0;
    tick(3);
    n_tests++;
    if ({op_o, in1_o, in2_o, busy_o, mode_o} !== 71'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got op=%h in1=%h in2=%h busy=%b mode=%0d, want all 0",
               op_o, in1_o, in2_o, busy_o, mode_o);
    end
    n_tests++;
    if (HEX !== HEX_RST) begin
      n_fail++;
      $display("FAIL reset_hex: got %h want %h", HEX, HEX_RST);
    end
    RST = 1'b0;
    tick(20);
    n_tests++;
    if (mode_o !== 2'd0 || busy_o !== 1'b0 || HEX !== HEX_RST) begin
      n_fail++;
      $display("FAIL reset_release: got mode=%0d busy=%b hex=%h, want 0 0 %h",
               mode_o, busy_o, HEX, HEX_RST);
    end
  endtask

  task automatic test_load();
    SW = 18'h0_1234;
    press(4'b0001, 10);
    m_in1 = 32'h0000_1234;
    n_tests++;
    if (in1_o !== m_in1) begin
      n_fail++;
      $display("FAIL load_in1: got %h want %h", in1_o, m_in1);
    end
    press(4'b1000, 10);
    m_mode = m_mode + 2'd1;
    n_tests++;
    if (mode_o !== m_mode) begin
      n_fail++;
      $display("FAIL long_press_single: got mode %0d want %0d", mode_o, m_mode);
    end
    n_tests++;
    if (HEX !== exp_hex(disp_src())) begin
      n_fail++;
      $display("FAIL hex_in1: got %h want %h", HEX, exp_hex(disp_src()));
    end
  endtask

  task automatic test_bounce();
    SW = 18'h0_5555;
    press(4'b0001, 3);
    n_tests++;
    if (in1_o !== m_in1) begin
      n_fail++;
      $display("FAIL bounce_3clk_load: got %h want %h", in1_o, m_in1);
    end
    press(4'b1000, 3);
    n_tests++;
    if (mode_o !== m_mode) begin
      n_fail++;
      $display("FAIL bounce_3clk_mode: got %0d want %0d", mode_o, m_mode);
    end
    press(4'b1000, 4);
    m_mode = m_mode + 2'd1;
    n_tests++;
    if (mode_o !== m_mode) begin
      n_fail++;
      $display("FAIL press_4clk_mode: got %0d want %0d", mode_o, m_mode);
    end
  endtask

  task automatic test_sign();
    SW = {1'b1, 1'b1, 16'h8000};
    press(4'b0001, 8);
    m_in2 = 32'hFFFF_8000;
    n_tests++;
    if (in2_o !== m_in2 || in1_o !== m_in1) begin
      n_fail++;
      $display("FAIL sign_in2: got in2=%h in1=%h want %h %h", in2_o, in1_o, m_in2, m_in1);
    end
  endtask

  task automatic test_mode3();
    SW = 18'h0_0005;
    press(4'b0010, 8);
    m_op = 4'h5;
    set_mode(2'd3);
    n_tests++;
    if (HEX !== {{7{7'b1111111}}, 7'b0010010} || op_o !== 4'h5) begin
      n_fail++;
      $display("FAIL mode3_op5: got hex=%h op=%h want %h 5",
               HEX, op_o, {{7{7'b1111111}}, 7'b0010010});
    end
  endtask

  task automatic test_exec_fixed();
    int unsigned b0;
    bit          seen;
    logic [55:0] old_hex;
    set_mode(2'd0);
    old_hex = exp_hex(m_res);
    fixed_en = 1'b1; fixed_val = 32'hDEAD_BEEF;
    b0 = busy_cycles;
    @(negedge CLK);
    KEY = 4'b1011;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge CLK);
      if (busy_o === 1'b1) seen = 1'b1;
    end
    for (int i = 0; i < 10 && busy_o === 1'b1; i++) @(negedge CLK);
    n_tests++;
    if (!seen || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL exec_timeout: seen=%b busy=%b, want busy pulse", seen, busy_o);
    end
    n_tests++;
    if (HEX !== old_hex) begin
      n_fail++;
      $display("FAIL hex_reg_delay: got %h want %h", HEX, old_hex);
    end
    @(negedge CLK);
    m_res = 32'hDEAD_BEEF;
    n_tests++;
    if (HEX !== {SEG[13], SEG[14], SEG[10], SEG[13], SEG[11], SEG[14], SEG[14], SEG[15]}) begin
      n_fail++;
      $display("FAIL hex_deadbeef: got %h want %h", HEX, exp_hex(m_res));
    end
    KEY = 4'hF;
    tick(12);
    n_tests++;
    if (busy_cycles - b0 != 3) begin
      n_fail++;
      $display("FAIL busy_len: got %0d want 3", busy_cycles - b0);
    end
    fixed_en = 1'b0;
  endtask

  task automatic test_exec_discard();
    int unsigned b0;
    SW = 18'h0_0ABC;
    tick(3);
    b0 = busy_cycles;
    @(negedge CLK);
    KEY = 4'b1011;
    @(negedge CLK);
    KEY = 4'b0010;
    tick(10);
    KEY = 4'hF;
    tick(12);
    m_res  = alu(m_in1, m_in2, m_op);
    m_mode = m_mode + 2'd1;
    n_tests++;
    if (in1_o !== m_in1 || mode_o !== m_mode) begin
      n_fail++;
      $display("FAIL exec_discard: got in1=%h mode=%0d want %h %0d", in1_o, mode_o, m_in1, m_mode);
    end
    n_tests++;
    if (busy_cycles - b0 != 3) begin
      n_fail++;
      $display("FAIL exec_discard_busy: got %0d want 3", busy_cycles - b0);
    end
    set_mode(2'd0);
    n_tests++;
    if (HEX !== exp_hex(m_res)) begin
      n_fail++;
      $display("FAIL exec_result: got %h want %h", HEX, exp_hex(m_res));
    end
  endtask

  task automatic test_back_to_back();
    SW = {1'b0, 1'b0, 16'h1237};
    press(4'b0111, 8);
    m_in1 = 32'h0000_1237;
    m_op  = 4'h7;
    m_res = alu(m_in1, m_in2, m_op);
    n_tests++;
    if (in1_o !== m_in1 || op_o !== m_op) begin
      n_fail++;
      $display("FAIL simul_load: got in1=%h op=%h want %h %h", in1_o, op_o, m_in1, m_op);
    end
    n_tests++;
    if (HEX !== exp_hex(disp_src())) begin
      n_fail++;
      $display("FAIL simul_result: got %h want %h", HEX, exp_hex(disp_src()));
    end
  endtask

  task automatic test_random();
    int unsigned k;
    logic [17:0] s;
    for (int it = 0; it < 30; it++) begin
      k = $urandom_range(0, 3);
      s = 18'($urandom);
      SW = s;
      press(4'(1 << k), 6 + int'($urandom_range(0, 4)));
      case (k)
        0: if (s[17]) m_in2 = sw_ext(s); else m_in1 = sw_ext(s);
        1: m_op = s[3:0];
        2: m_res = alu(m_in1, m_in2, m_op);
        default: m_mode = m_mode + 2'd1;
      endcase
      n_tests++;
      if ({in1_o, in2_o, op_o, mode_o, busy_o} !== {m_in1, m_in2, m_op, m_mode, 1'b0}) begin
        n_fail++;
        $display("FAIL rand_regs[%0d]: got %h %h %h %0d %b want %h %h %h %0d 0",
                 it, in1_o, in2_o, op_o, mode_o, busy_o, m_in1, m_in2, m_op, m_mode);
      end
      n_tests++;
      if (HEX !== exp_hex(disp_src())) begin
        n_fail++;
        $display("FAIL rand_hex[%0d]: got %h want %h", it, HEX, exp_hex(disp_src()));
      end
    end
  endtask

  task automatic test_reset_exec();
    bit seen;
    set_mode(2'd1);
    @(negedge CLK);
    KEY = 4'b1011;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge CLK);
      if (busy_o === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rst_exec_start: busy got %b want 1", busy_o);
    end
    #2;
    RST = 1'b1;
    KEY = 4'hF;
    #1;
    n_tests++;
    if ({op_o, in1_o, in2_o, busy_o, mode_o} !== 71'h0 || HEX !== HEX_RST) begin
      n_fail++;
      $display("FAIL rst_async: got op=%h in1=%h in2=%h busy=%b mode=%0d hex=%h, want 0s %h",
               op_o, in1_o, in2_o, busy_o, mode_o, HEX, HEX_RST);
    end
    tick(2);
    RST = 1'b0;
    tick(20);
    n_tests++;
    if (mode_o !== 2'd0 || busy_o !== 1'b0 || HEX !== HEX_RST) begin
      n_fail++;
      $display("FAIL rst_no_capture: got mode=%0d busy=%b hex=%h want 0 0 %h",
               mode_o, busy_o, HEX, HEX_RST);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_bounce();
    test_sign();
    test_mode3();
    test_exec_fixed();
    test_exec_discard();
    test_back_to_back();
    test_random();
    test_reset_exec();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
